lanes_dispatch: RTL and testbench
=================================

LANES_DISPATCH -- requirements
Module: lanes_dispatch

Interface
REQ-001 Parameters SHALL be: LANES, default 4, number of ALU lanes; WIDTH, default 32, operand width; TIMEOUT, default 64, maximum WAIT cycles before abort.
REQ-002 Clocking and reset SHALL be: one clock, clk; reset rst_n, asynchronous, active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  vector op request present.
REQ-006 req_ready  output  1  dispatcher accepts request this cycle.
REQ-007 req_func  input  1  0 = add, 1 = mul.
REQ-008 req_a, req_b  input  LANES*WIDTH  packed operands; lane i occupies bits [WIDTH*i+WIDTH-1 : WIDTH*i].
REQ-009 lane_a, lane_b  output  LANES*WIDTH  operands driven to lane ALUs, same packing.
REQ-010 lane_func  output  1  func driven to all lanes.
REQ-011 lane_result  input  LANES*WIDTH  per-lane ALU results.
REQ-012 lane_ready_add, lane_ready_mul  input  LANES  per-lane completion flags.
REQ-013 lane_busy_add, lane_busy_mul  input  LANES  per-lane unit-occupied flags.
REQ-014 rsp_valid  output  1  result vector available.
REQ-015 rsp_ready  input  1  consumer accepts result.
REQ-016 rsp_data  output  LANES*WIDTH  captured results, same packing.
REQ-017 rsp_err  output  1  op aborted by timeout; qualified by rsp_valid.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-019 req_ready SHALL be 1 only in IDLE; a transfer occurs when req_valid && req_ready, which latches req_a, req_b, req_func and moves to ISSUE.
REQ-020 lane_a, lane_b, lane_func SHALL be driven from the latched registers and held stable from ISSUE until leaving WAIT.
REQ-021 ISSUE SHALL stay while any lane_busy of the selected unit is 1 and move to WAIT on the first cycle all are 0.
REQ-022 Ready flags arriving in IDLE or ISSUE SHALL be ignored as stale.
REQ-023 In WAIT, a lane whose selected ready flag is 1 and whose done bit is clear SHALL capture its lane_result slice and set its done bit that cycle; later pulses on a done lane SHALL be ignored.
REQ-024 Simultaneous ready on several lanes SHALL capture all of them in the same cycle.
REQ-025 WAIT SHALL move to DONE on the cycle after all done bits are set, so rsp_valid rises exactly one cycle after the last capture.
REQ-026 A WAIT cycle counter SHALL increment each WAIT cycle; on reaching TIMEOUT with any lane not done, the FSM SHALL go to DONE with rsp_err=1, and undone lanes SHALL read 0 in rsp_data.
REQ-027 In DONE, rsp_valid=1 and rsp_data/rsp_err SHALL be stable until rsp_ready=1.
REQ-028 On handshake, the FSM SHALL return to IDLE, clearing done bits, counter and rsp_err.
REQ-029 No new request SHALL be accepted in the same cycle as a DONE handshake; req_ready rises the next cycle.
REQ-030 The counter SHALL be sized clog2(TIMEOUT+1) bits and SHALL NOT wrap.

Reset
REQ-031 On rst_n=0 the state SHALL go to IDLE with req_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0, lane_a=0, lane_b=0, lane_func=0, done bits=0, counter=0, regardless of current state.
REQ-032 Reset asserted mid-operation SHALL discard the op; no response SHALL be produced after release.

Structure
REQ-033 Package vec_pkg SHALL hold LANES, WIDTH, the func encodings FUNC_ADD=0 and FUNC_MUL=1, and the state enum.
REQ-034 The per-lane capture register and done bit SHALL be one sub-module, lane_capture, instantiated LANES times via generate.

Verification
REQ-035 Add op, A=0x3F800000 on all lanes, B=0x40000000; ready_add pulses at 2,4,3,5 cycles into WAIT -> rsp_valid rises 6 cycles into WAIT, rsp_data equals each lane_result sampled at its pulse, rsp_err=0.
REQ-036 Mul op with lane_busy_mul=4'b0010 for 3 cycles after acceptance -> ISSUE held 3 cycles, then WAIT; ready_mul pulses before WAIT are not captured.
REQ-037 All four ready_mul pulse in the same cycle, with lane 0 pulsing again 2 cycles later -> single capture per lane, rsp_data unchanged by the second pulse.
REQ-038 TIMEOUT=8, lane 3 never ready -> rsp_valid after 8 WAIT cycles, rsp_err=1, lane 3 slice = 0x00000000.
REQ-039 rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data stable; req_ready=0 throughout; req_ready=1 the cycle after handshake.
REQ-040 rst_n pulsed low during WAIT -> all outputs at REQ-031 values asynchronously; no rsp_valid afterwards until a new request.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared constants and state encoding for the vector lane dispatcher.
package vec_pkg;

  localparam int LANES = 4;
  localparam int WIDTH = 32;

  localparam logic FUNC_ADD = 1'b0;
  localparam logic FUNC_MUL = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/lane_capture.sv
// One lane's result register and done flag; only the first capture after a clear is kept.
module lane_capture #(
  parameter int WIDTH = vec_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture,
  input  logic             clear,
  input  logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] data,
  output logic             done
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      done <= 1'b0;
    end else if (clear) begin
      data <= '0;
      done <= 1'b0;
    end else if (capture && !done) begin
      data <= result;
      done <= 1'b1;
    end
  end

endmodule

// File: rtl/lanes_dispatch.sv
// Issues one vector op to all lanes, collects per-lane results and returns them as
// a single response, aborting with an error flag if lanes do not finish in time.
module lanes_dispatch #(
  parameter int LANES   = vec_pkg::LANES,
  parameter int WIDTH   = vec_pkg::WIDTH,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_func,
  input  logic [LANES*WIDTH-1:0] req_a,
  input  logic [LANES*WIDTH-1:0] req_b,
  output logic [LANES*WIDTH-1:0] lane_a,
  output logic [LANES*WIDTH-1:0] lane_b,
  output logic                   lane_func,
  input  logic [LANES*WIDTH-1:0] lane_result,
  input  logic [LANES-1:0]       lane_ready_add,
  input  logic [LANES-1:0]       lane_ready_mul,
  input  logic [LANES-1:0]       lane_busy_add,
  input  logic [LANES-1:0]       lane_busy_mul,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [LANES*WIDTH-1:0] rsp_data,
  output logic                   rsp_err
);

  import vec_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t state, state_next;

  logic [LANES*WIDTH-1:0] a_q, b_q;
  logic                   func_q;
  logic [CNT_W-1:0]       wait_cnt;
  logic                   err_q;
  logic [LANES-1:0]       done, busy_sel, ready_sel, capture_en;
  logic                   all_done_next, timeout_hit, accept, rsp_fire;

  assign busy_sel      = (func_q == FUNC_MUL) ? lane_busy_mul  : lane_busy_add;
  assign ready_sel     = (func_q == FUNC_MUL) ? lane_ready_mul : lane_ready_add;
  assign capture_en    = (state == WAIT) ? ready_sel : '0;
  // Counting this cycle's captures lets the response follow the last capture directly.
  assign all_done_next = &(done | capture_en);
  assign timeout_hit   = (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign accept        = (state == IDLE) && req_valid;
  assign rsp_fire      = (state == DONE) && rsp_ready;

  assign lane_a    = a_q;
  assign lane_b    = b_q;
  assign lane_func = func_q;
  assign rsp_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = ISSUE;
      end
      ISSUE: if (busy_sel == '0) state_next = WAIT;
      WAIT:  if (all_done_next || timeout_hit) state_next = DONE;
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      func_q <= 1'b0;
    end else if (accept) begin
      a_q    <= req_a;
      b_q    <= req_b;
      func_q <= req_func;
    end
  end

  // Saturates at TIMEOUT so a stalled op can never wrap back to a small count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (rsp_fire) begin
      wait_cnt <= '0;
    end else if (state == WAIT && wait_cnt != CNT_W'(TIMEOUT)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (rsp_fire) begin
      err_q <= 1'b0;
    end else if (state == WAIT && timeout_hit && !all_done_next) begin
      err_q <= 1'b1;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_capture #(.WIDTH(WIDTH)) u_capture (
      .clk     (clk),
      .rst_n   (rst_n),
      .capture (capture_en[i]),
      .clear   (rsp_fire),
      .result  (lane_result[i*WIDTH +: WIDTH]),
      .data    (rsp_data[i*WIDTH +: WIDTH]),
      .done    (done[i])
    );
  end

endmodule

// File: tb/tb_lanes_dispatch.sv
// Randomized bench for lanes_dispatch; expected responses come from per-lane pulse
// schedules (first pulse time, timeout) rather than from cycle-level state tracking.
module tb_lanes_dispatch;

  localparam int LANES   = 4;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 8;
  localparam int NEVER   = 1000;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   req_valid, req_ready, req_func;
  logic [LANES*WIDTH-1:0] req_a, req_b, lane_a, lane_b, lane_result, rsp_data;
  logic                   lane_func, rsp_valid, rsp_ready, rsp_err;
  logic [LANES-1:0]       lane_ready_add, lane_ready_mul, lane_busy_add, lane_busy_mul;

  int checks = 0;
  int errors = 0;

  logic [LANES*WIDTH-1:0] op_a, op_b;
  logic                   op_func;
  int                     first_pulse[LANES];
  int                     extra_pulse[LANES];
  int                     busy_cycles;
  logic [LANES-1:0]       busy_mask;
  int                     hold_cycles;

  lanes_dispatch #(.LANES(LANES), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_func       (req_func),
    .req_a          (req_a),
    .req_b          (req_b),
    .lane_a         (lane_a),
    .lane_b         (lane_b),
    .lane_func      (lane_func),
    .lane_result    (lane_result),
    .lane_ready_add (lane_ready_add),
    .lane_ready_mul (lane_ready_mul),
    .lane_busy_add  (lane_busy_add),
    .lane_busy_mul  (lane_busy_mul),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [LANES*WIDTH-1:0] got,
                              input logic [LANES*WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LANES*WIDTH-1:0] rand_vec();
    logic [LANES*WIDTH-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*WIDTH +: WIDTH] = $urandom;
    return v;
  endfunction

  // w is the 1-based WAIT cycle index of the op; w < 1 means the dispatcher is not yet waiting.
  task automatic drive_lanes(input int w, input bit busy_now);
    logic [LANES-1:0] sel_rdy, sel_busy;
    lane_result = rand_vec();
    for (int i = 0; i < LANES; i++) begin
      if (w < 1) sel_rdy[i] = 1'($urandom_range(0, 1));
      else sel_rdy[i] = (w == first_pulse[i]) || (w == extra_pulse[i]) ||
                        (w > first_pulse[i] && $urandom_range(0, 1) == 1);
    end
    sel_busy = busy_now ? busy_mask : '0;
    if (op_func) begin
      lane_ready_mul = sel_rdy;
      lane_busy_mul  = sel_busy;
      lane_ready_add = LANES'($urandom);
      lane_busy_add  = LANES'($urandom);
    end else begin
      lane_ready_add = sel_rdy;
      lane_busy_add  = sel_busy;
      lane_ready_mul = LANES'($urandom);
      lane_busy_mul  = LANES'($urandom);
    end
  endtask

  task automatic apply_stimulus(input string name);
    logic [LANES*WIDTH-1:0] exp_data;
    bit exp_err;
    int last, w_done, w, span;
    exp_err = 1'b0;
    last    = 0;
    for (int i = 0; i < LANES; i++) begin
      if (first_pulse[i] > TIMEOUT) exp_err = 1'b1;
      else if (first_pulse[i] > last) last = first_pulse[i];
    end
    w_done   = exp_err ? TIMEOUT + 1 : last + 1;
    exp_data = '0;
    span     = busy_cycles + 1;

    @(negedge clk);
    check_output({name, "_req_ready_idle"}, req_ready, 1);
    req_valid = 1'b1;
    req_a     = op_a;
    req_b     = op_b;
    req_func  = op_func;
    rsp_ready = 1'b0;
    drive_lanes(-1, 1'b0);

    for (int cyc = 1; cyc <= span + w_done; cyc++) begin
      @(negedge clk);
      w         = cyc - span;
      req_valid = 1'($urandom_range(0, 1));
      req_a     = rand_vec();
      req_b     = rand_vec();
      req_func  = 1'($urandom_range(0, 1));
      check_output({name, "_rsp_valid"}, rsp_valid, (w >= w_done));
      check_output({name, "_req_ready_busy"}, req_ready, 0);
      if (w < w_done) begin
        check_output({name, "_lane_a"}, lane_a, op_a);
        check_output({name, "_lane_b"}, lane_b, op_b);
        check_output({name, "_lane_func"}, lane_func, op_func);
      end
      drive_lanes(w, cyc <= busy_cycles);
      if (w >= 1 && w <= TIMEOUT)
        for (int i = 0; i < LANES; i++)
          if (first_pulse[i] == w) exp_data[i*WIDTH +: WIDTH] = lane_result[i*WIDTH +: WIDTH];
    end

    check_output({name, "_rsp_data"}, rsp_data, exp_data);
    check_output({name, "_rsp_err"}, rsp_err, exp_err);
    rsp_ready = (hold_cycles == 0);

    for (int h = 1; h <= hold_cycles; h++) begin
      @(negedge clk);
      req_valid = 1'($urandom_range(0, 1));
      check_output({name, "_hold_valid"}, rsp_valid, 1);
      check_output({name, "_hold_data"}, rsp_data, exp_data);
      check_output({name, "_hold_err"}, rsp_err, exp_err);
      check_output({name, "_hold_req_ready"}, req_ready, 0);
      drive_lanes(w_done + h, 1'b0);
      rsp_ready = (h == hold_cycles);
    end

    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check_output({name, "_post_valid"}, rsp_valid, 0);
    check_output({name, "_post_req_ready"}, req_ready, 1);
    check_output({name, "_post_err"}, rsp_err, 0);
    drive_lanes(-1, 1'b0);
  endtask

  task automatic check_reset_values(input string name);
    check_output({name, "_req_ready"}, req_ready, 1);
    check_output({name, "_rsp_valid"}, rsp_valid, 0);
    check_output({name, "_rsp_err"}, rsp_err, 0);
    check_output({name, "_rsp_data"}, rsp_data, 0);
    check_output({name, "_lane_a"}, lane_a, 0);
    check_output({name, "_lane_b"}, lane_b, 0);
    check_output({name, "_lane_func"}, lane_func, 0);
  endtask

  // Starts an op, captures one lane, then pulls reset asynchronously in the middle of WAIT.
  task automatic reset_mid_wait();
    op_a = rand_vec();
    op_b = rand_vec();
    op_func = 1'b1;
    busy_cycles = 0;
    busy_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      first_pulse[i] = NEVER;
      extra_pulse[i] = 0;
    end
    first_pulse[0] = 1;
    @(negedge clk);
    req_valid = 1'b1;
    req_a = op_a;
    req_b = op_b;
    req_func = op_func;
    drive_lanes(-1, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    drive_lanes(0, 1'b0);
    @(negedge clk);
    drive_lanes(1, 1'b0);
    @(negedge clk);
    drive_lanes(2, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_values("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 3; k < 7; k++) begin
      drive_lanes(k, 1'b0);
      @(negedge clk);
      check_output("rst_after_valid", rsp_valid, 0);
      check_output("rst_after_req_ready", req_ready, 1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_func = 1'b0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    lane_result = '0;
    lane_ready_add = '0;
    lane_ready_mul = '0;
    lane_busy_add = '0;
    lane_busy_mul = '0;
    op_func = 1'b0;
    #7 check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    op_a = {LANES{32'h3F800000}};
    op_b = {LANES{32'h40000000}};
    op_func = 1'b0;
    busy_cycles = 0;
    busy_mask = '0;
    hold_cycles = 0;
    first_pulse = '{2, 4, 3, 5};
    extra_pulse = '{0, 0, 0, 0};
    apply_stimulus("add_staggered");

    op_a = rand_vec();
    op_b = rand_vec();
    op_func = 1'b1;
    busy_cycles = 3;
    busy_mask = 4'b0010;
    first_pulse = '{1, 3, 2, 4};
    apply_stimulus("mul_busy");

    busy_cycles = 0;
    busy_mask = '0;
    hold_cycles = 3;
    first_pulse = '{3, 3, 3, 3};
    extra_pulse = '{5, 0, 0, 0};
    apply_stimulus("mul_same_cycle");

    op_func = 1'b0;
    hold_cycles = 1;
    first_pulse = '{2, 6, 1, NEVER};
    extra_pulse = '{0, 0, 0, 0};
    apply_stimulus("timeout_lane3");

    op_func = 1'b1;
    hold_cycles = 5;
    first_pulse = '{1, 1, 2, 2};
    apply_stimulus("hold_rsp");

    reset_mid_wait();

    for (int n = 0; n < 24; n++) begin
      op_a = rand_vec();
      op_b = rand_vec();
      op_func = 1'($urandom_range(0, 1));
      busy_cycles = $urandom_range(0, 3);
      busy_mask = LANES'($urandom_range(1, (1 << LANES) - 1));
      hold_cycles = $urandom_range(0, 3);
      for (int i = 0; i < LANES; i++) begin
        first_pulse[i] = $urandom_range(1, TIMEOUT + 2);
        extra_pulse[i] = ($urandom_range(0, 1) == 1) ? first_pulse[i] + $urandom_range(1, 3) : 0;
      end
      apply_stimulus($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
